// File: rtl/video_timing_gen.sv
// Parametrised raster timing generator: H/V counters, sync/blank decode, tile and
// line/frame strobes, frame counter and a vblank IRQ with CPU acknowledge.

module video_timing_gen_param_chk #(
  parameter int HW        = 9,
  parameter int VW        = 9,
  parameter int H_TOTAL   = 384,
  parameter int H_ACTIVE  = 256,
  parameter int HS_START  = 288,
  parameter int HS_WIDTH  = 32,
  parameter int V_TOTAL   = 264,
  parameter int V_ACTIVE  = 224,
  parameter int VS_START  = 240,
  parameter int VS_WIDTH  = 8,
  parameter int IRQ_LINE  = 224,
  parameter int TILE_LOG2 = 3
);
  if (HS_START + HS_WIDTH > H_TOTAL) begin : g_bad_hs
    $error("video_timing_gen: hsync window exceeds H_TOTAL");
  end
  if (VS_START + VS_WIDTH > V_TOTAL) begin : g_bad_vs
    $error("video_timing_gen: vsync window exceeds V_TOTAL");
  end
  if (H_ACTIVE > H_TOTAL || V_ACTIVE > V_TOTAL) begin : g_bad_active
    $error("video_timing_gen: active area larger than total");
  end
  if (H_TOTAL > (1 << HW) || V_TOTAL > (1 << VW)) begin : g_bad_width
    $error("video_timing_gen: counter width too small for totals");
  end
  if (IRQ_LINE >= V_TOTAL) begin : g_bad_irq
    $error("video_timing_gen: IRQ_LINE outside frame");
  end
  if (TILE_LOG2 < 1 || (H_TOTAL % (1 << TILE_LOG2)) != 0) begin : g_bad_tile
    $error("video_timing_gen: H_TOTAL must be a multiple of the tile width");
  end
endmodule

module video_timing_gen #(
  parameter int HW        = 9,
  parameter int VW        = 9,
  parameter int H_TOTAL   = 384,
  parameter int H_ACTIVE  = 256,
  parameter int HS_START  = 288,
  parameter int HS_WIDTH  = 32,
  parameter int V_TOTAL   = 264,
  parameter int V_ACTIVE  = 224,
  parameter int VS_START  = 240,
  parameter int VS_WIDTH  = 8,
  parameter int IRQ_LINE  = 224,
  parameter int TILE_LOG2 = 3,
  parameter int FW        = 8,
  parameter int SYNC_POL  = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          pix_ce,
  input  logic          irq_ack,
  output logic [HW-1:0] hcnt,
  output logic [VW-1:0] vcnt,
  output logic          hsync,
  output logic          vsync,
  output logic          csync,
  output logic          hblank,
  output logic          vblank,
  output logic          blank,
  output logic          tile_load,
  output logic          line_start,
  output logic          frame_start,
  output logic [FW-1:0] frame_cnt,
  output logic          irq_n
);

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] IRQ_V  = VW'(IRQ_LINE);
  // One extra bit so window ends equal to 2^HW / 2^VW stay representable.
  localparam logic [HW:0]   H_ACT  = (HW+1)'(H_ACTIVE);
  localparam logic [HW:0]   HS_LO  = (HW+1)'(HS_START);
  localparam logic [HW:0]   HS_HI  = (HW+1)'(HS_START + HS_WIDTH);
  localparam logic [VW:0]   V_ACT  = (VW+1)'(V_ACTIVE);
  localparam logic [VW:0]   VS_LO  = (VW+1)'(VS_START);
  localparam logic [VW:0]   VS_HI  = (VW+1)'(VS_START + VS_WIDTH);
  localparam logic          SYNC_ACT = (SYNC_POL != 0);

  video_timing_gen_param_chk #(
    .HW(HW), .VW(VW), .H_TOTAL(H_TOTAL), .H_ACTIVE(H_ACTIVE),
    .HS_START(HS_START), .HS_WIDTH(HS_WIDTH), .V_TOTAL(V_TOTAL),
    .V_ACTIVE(V_ACTIVE), .VS_START(VS_START), .VS_WIDTH(VS_WIDTH),
    .IRQ_LINE(IRQ_LINE), .TILE_LOG2(TILE_LOG2)
  ) u_param_chk ();

  logic [HW-1:0] hcnt_q, hcnt_d;
  logic [VW-1:0] vcnt_q, vcnt_d;
  logic [FW-1:0] frame_cnt_q, frame_cnt_d;
  logic          hsync_q, hsync_d;
  logic          vsync_q, vsync_d;
  logic          csync_q, csync_d;
  logic          hblank_q, hblank_d;
  logic          vblank_q, vblank_d;
  logic          tile_load_q, tile_load_d;
  logic          line_start_q, line_start_d;
  logic          frame_start_q, frame_start_d;
  logic          irq_n_q, irq_n_d;
  logic          hs_on_s, vs_on_s, irq_set_s;

  always_comb begin
    hcnt_d      = hcnt_q;
    vcnt_d      = vcnt_q;
    frame_cnt_d = frame_cnt_q;
    if (pix_ce) begin
      if (hcnt_q == H_LAST) begin
        hcnt_d = '0;
        if (vcnt_q == V_LAST) begin
          vcnt_d      = '0;
          frame_cnt_d = frame_cnt_q + FW'(1);
        end else begin
          vcnt_d = vcnt_q + VW'(1);
        end
      end else begin
        hcnt_d = hcnt_q + HW'(1);
      end
    end else begin
      hcnt_d = hcnt_q;
    end
  end

  // Outputs are decoded from the next counter values so they line up with hcnt/vcnt.
  always_comb begin
    hs_on_s       = ({1'b0, hcnt_d} >= HS_LO) && ({1'b0, hcnt_d} < HS_HI);
    vs_on_s       = ({1'b0, vcnt_d} >= VS_LO) && ({1'b0, vcnt_d} < VS_HI);
    hsync_d       = hsync_q;
    vsync_d       = vsync_q;
    csync_d       = csync_q;
    hblank_d      = hblank_q;
    vblank_d      = vblank_q;
    tile_load_d   = 1'b0;
    line_start_d  = 1'b0;
    frame_start_d = 1'b0;
    irq_set_s     = 1'b0;
    if (pix_ce) begin
      hsync_d       = hs_on_s ? SYNC_ACT : ~SYNC_ACT;
      vsync_d       = vs_on_s ? SYNC_ACT : ~SYNC_ACT;
      csync_d       = (hs_on_s || vs_on_s) ? SYNC_ACT : ~SYNC_ACT;
      hblank_d      = ({1'b0, hcnt_d} >= H_ACT);
      vblank_d      = ({1'b0, vcnt_d} >= V_ACT);
      tile_load_d   = &hcnt_d[TILE_LOG2-1:0];
      line_start_d  = (hcnt_d == '0);
      frame_start_d = (hcnt_d == '0) && (vcnt_d == '0);
      irq_set_s     = (hcnt_d == '0) && (vcnt_d == IRQ_V);
    end else begin
      irq_set_s = 1'b0;
    end
  end

  // A new IRQ beats an acknowledge arriving on the same edge.
  always_comb begin
    irq_n_d = irq_n_q;
    if (irq_set_s) begin
      irq_n_d = 1'b0;
    end else if (irq_ack) begin
      irq_n_d = 1'b1;
    end else begin
      irq_n_d = irq_n_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hcnt_q        <= '0;
      vcnt_q        <= '0;
      frame_cnt_q   <= '0;
      hsync_q       <= ~SYNC_ACT;
      vsync_q       <= ~SYNC_ACT;
      csync_q       <= ~SYNC_ACT;
      hblank_q      <= 1'b0;
      vblank_q      <= 1'b0;
      tile_load_q   <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      irq_n_q       <= 1'b1;
    end else begin
      hcnt_q        <= hcnt_d;
      vcnt_q        <= vcnt_d;
      frame_cnt_q   <= frame_cnt_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      csync_q       <= csync_d;
      hblank_q      <= hblank_d;
      vblank_q      <= vblank_d;
      tile_load_q   <= tile_load_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      irq_n_q       <= irq_n_d;
    end
  end

  assign hcnt        = hcnt_q;
  assign vcnt        = vcnt_q;
  assign frame_cnt   = frame_cnt_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign csync       = csync_q;
  assign hblank      = hblank_q;
  assign vblank      = vblank_q;
  assign blank       = hblank_q | vblank_q;
  assign tile_load   = tile_load_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;
  assign irq_n       = irq_n_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: a default-parameter instance for line timing and a
// small active-high-sync instance for frame, IRQ and mid-frame reset sequences.

module tb_video_timing_gen;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic pix_ce = 1'b0;
  logic irq_ack = 1'b0;

  always #5 clk = ~clk;

  logic [8:0] d_hcnt, d_vcnt;
  logic [7:0] d_frame_cnt;
  logic d_hsync, d_vsync, d_csync, d_hblank, d_vblank, d_blank;
  logic d_tile_load, d_line_start, d_frame_start, d_irq_n;

  video_timing_gen dut (
    .clk(clk), .rst_n(rst_n), .pix_ce(pix_ce), .irq_ack(irq_ack),
    .hcnt(d_hcnt), .vcnt(d_vcnt), .hsync(d_hsync), .vsync(d_vsync),
    .csync(d_csync), .hblank(d_hblank), .vblank(d_vblank), .blank(d_blank),
    .tile_load(d_tile_load), .line_start(d_line_start),
    .frame_start(d_frame_start), .frame_cnt(d_frame_cnt), .irq_n(d_irq_n)
  );

  logic [4:0] s_hcnt;
  logic [3:0] s_vcnt;
  logic [1:0] s_frame_cnt;
  logic s_hsync, s_vsync, s_csync, s_hblank, s_vblank, s_blank;
  logic s_tile_load, s_line_start, s_frame_start, s_irq_n;

  video_timing_gen #(
    .HW(5), .VW(4), .H_TOTAL(16), .H_ACTIVE(12), .HS_START(12), .HS_WIDTH(2),
    .V_TOTAL(10), .V_ACTIVE(6), .VS_START(7), .VS_WIDTH(2), .IRQ_LINE(6),
    .TILE_LOG2(2), .FW(2), .SYNC_POL(1)
  ) dut_s (
    .clk(clk), .rst_n(rst_n), .pix_ce(pix_ce), .irq_ack(irq_ack),
    .hcnt(s_hcnt), .vcnt(s_vcnt), .hsync(s_hsync), .vsync(s_vsync),
    .csync(s_csync), .hblank(s_hblank), .vblank(s_vblank), .blank(s_blank),
    .tile_load(s_tile_load), .line_start(s_line_start),
    .frame_start(s_frame_start), .frame_cnt(s_frame_cnt), .irq_n(s_irq_n)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_to(input int v, input int h, input string name);
    int n = 0;
    while (!(s_vcnt == 4'(v) && s_hcnt == 5'(h)) && n < 400) begin
      tick();
      n++;
    end
    check({name, " reached"}, 32'(s_vcnt == 4'(v) && s_hcnt == 5'(h)), 32'd1);
  endtask

  typedef struct {
    logic       rst_n;
    logic       ce;
    logic [8:0] hcnt;
    logic       hsync;
    logic       tile;
    logic       lstart;
    logic       hblank;
  } vec_t;

  vec_t vecs[16];

  initial begin
    int hs_cnt, hs_first, hs_last, hb_rise, tile_cnt, tile_bad, ls_cnt, ls_h, ls_v, h_bad;
    int exp_h, exp_v, exp_f, ls_seen, ls_at0, ls_at1, hold_bad, wide_bad;
    logic prev_hb, prev_tile, eirq, prev_vs, prev_irq;
    logic [8:0] prev_h;
    int mm, vb_rise, vs_min, vs_max, vs_midline, fc_idx, irq_v, irq_h;
    int fc[4];
    logic [20:0] act_v, exp_vv;
    logic ehs, evs;

    // rst_n, ce, hcnt, hsync, tile, line_start, hblank (default instance)
    vecs[0]  = '{1'b0, 1'b1, 9'd0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, 9'd0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 9'd0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 9'd0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 9'd0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, 9'd0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, 1'b1, 9'd1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{1'b1, 1'b1, 9'd2, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, 1'b1, 9'd3, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{1'b1, 1'b1, 9'd4, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{1'b1, 1'b1, 9'd5, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{1'b1, 1'b1, 9'd6, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[12] = '{1'b1, 1'b1, 9'd7, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[13] = '{1'b1, 1'b0, 9'd7, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[14] = '{1'b1, 1'b1, 9'd8, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[15] = '{1'b0, 1'b0, 9'd0, 1'b1, 1'b0, 1'b0, 1'b0};

    for (int i = 0; i < 16; i++) begin
      rst_n  = vecs[i].rst_n;
      pix_ce = vecs[i].ce;
      tick();
      check($sformatf("vec%0d hcnt", i), 32'(d_hcnt), 32'(vecs[i].hcnt));
      check($sformatf("vec%0d hsync", i), 32'(d_hsync), 32'(vecs[i].hsync));
      check($sformatf("vec%0d tile_load", i), 32'(d_tile_load), 32'(vecs[i].tile));
      check($sformatf("vec%0d line_start", i), 32'(d_line_start), 32'(vecs[i].lstart));
      check($sformatf("vec%0d hblank", i), 32'(d_hblank), 32'(vecs[i].hblank));
      if (!vecs[i].rst_n) begin
        check($sformatf("vec%0d rst vcnt", i), 32'(d_vcnt), 32'd0);
        check($sformatf("vec%0d rst frame_cnt", i), 32'(d_frame_cnt), 32'd0);
        check($sformatf("vec%0d rst irq_n", i), 32'(d_irq_n), 32'd1);
        check($sformatf("vec%0d rst frame_start", i), 32'(d_frame_start), 32'd0);
        check($sformatf("vec%0d rst vsync/csync", i), 32'({d_vsync, d_csync}), 32'd3);
        check($sformatf("vec%0d rst blanks", i), 32'({d_vblank, d_blank}), 32'd0);
      end
    end
    check("small rst sync inactive-high", 32'({s_hsync, s_vsync, s_csync}), 32'd0);

    // Full line on the default instance, pix_ce every cycle.
    rst_n = 1'b1; pix_ce = 1'b1;
    hs_cnt = 0; hs_first = -1; hs_last = -1; hb_rise = -1; tile_cnt = 0; tile_bad = 0;
    ls_cnt = 0; ls_h = -1; ls_v = -1; h_bad = 0; prev_hb = 1'b0;
    for (int i = 0; i < 384; i++) begin
      tick();
      if (32'(d_hcnt) != 32'((i + 1) % 384)) h_bad++;
      if (!d_hsync) begin
        hs_cnt++;
        if (hs_first < 0) hs_first = int'(d_hcnt);
        hs_last = int'(d_hcnt);
      end
      if (d_hblank && !prev_hb) hb_rise = int'(d_hcnt);
      prev_hb = d_hblank;
      if (d_tile_load) begin
        tile_cnt++;
        if (d_hcnt[2:0] != 3'b111) tile_bad++;
      end
      if (d_line_start) begin
        ls_cnt++; ls_h = int'(d_hcnt); ls_v = int'(d_vcnt);
      end
    end
    check("line hcnt sequence errors", 32'(h_bad), 32'd0);
    check("hsync low count", 32'(hs_cnt), 32'd32);
    check("hsync first hcnt", 32'(hs_first), 32'd288);
    check("hsync last hcnt", 32'(hs_last), 32'd319);
    check("hblank rise hcnt", 32'(hb_rise), 32'd256);
    check("tile_load count", 32'(tile_cnt), 32'd48);
    check("tile_load misplaced", 32'(tile_bad), 32'd0);
    check("line_start count", 32'(ls_cnt), 32'd1);
    check("line_start hcnt", 32'(ls_h), 32'd0);
    check("line_start vcnt", 32'(ls_v), 32'd1);
    check("hblank low after wrap", 32'(d_hblank), 32'd0);

    // pix_ce on every 4th cycle.
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    ls_seen = 0; ls_at0 = -1; ls_at1 = -1; hold_bad = 0; wide_bad = 0;
    prev_h = d_hcnt; prev_tile = 1'b0;
    for (int i = 0; i < 3200; i++) begin
      pix_ce = (i % 4 == 3);
      tick();
      if (!pix_ce && d_hcnt != prev_h) hold_bad++;
      if (!pix_ce && (d_tile_load || d_line_start || d_frame_start)) wide_bad++;
      if (d_tile_load && prev_tile) wide_bad++;
      if (d_line_start) begin
        if (ls_seen == 0) ls_at0 = i;
        if (ls_seen == 1) ls_at1 = i;
        ls_seen++;
      end
      prev_h = d_hcnt; prev_tile = d_tile_load;
    end
    check("ce4 line_start count", 32'(ls_seen), 32'd2);
    check("ce4 first line_start cycle", 32'(ls_at0), 32'd1535);
    check("ce4 line period", 32'(ls_at1 - ls_at0), 32'd1536);
    check("ce4 counters held", 32'(hold_bad), 32'd0);
    check("ce4 strobe width", 32'(wide_bad), 32'd0);

    // Four frames on the small instance against a reference model.
    pix_ce = 1'b1;
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    exp_h = 0; exp_v = 0; exp_f = 0; eirq = 1'b1; mm = 0;
    vb_rise = -1; vs_min = 99; vs_max = -1; vs_midline = 0; fc_idx = 0;
    irq_v = -1; irq_h = -1; prev_vs = 1'b0; prev_irq = 1'b1; prev_hb = 1'b0;
    for (int k = 0; k < 4; k++) fc[k] = -1;
    for (int i = 0; i < 640; i++) begin
      tick();
      if (exp_h == 15) begin
        exp_h = 0;
        if (exp_v == 9) begin exp_v = 0; exp_f = (exp_f + 1) % 4; end
        else exp_v++;
      end else exp_h++;
      if (exp_h == 0 && exp_v == 6) eirq = 1'b0;
      ehs = (exp_h >= 12 && exp_h < 14);
      evs = (exp_v >= 7 && exp_v < 9);
      exp_vv = {5'(exp_h), 4'(exp_v), ehs, evs, ehs | evs, 1'(exp_h >= 12), 1'(exp_v >= 6),
                1'(exp_h >= 12 || exp_v >= 6), 1'((exp_h % 4) == 3), 1'(exp_h == 0),
                1'(exp_h == 0 && exp_v == 0), 2'(exp_f), eirq};
      act_v = {s_hcnt, s_vcnt, s_hsync, s_vsync, s_csync, s_hblank, s_vblank, s_blank,
               s_tile_load, s_line_start, s_frame_start, s_frame_cnt, s_irq_n};
      if (act_v !== exp_vv) mm++;
      if (s_vblank && !prev_hb) vb_rise = int'(s_vcnt);
      prev_hb = s_vblank;
      if (s_vsync) begin
        if (int'(s_vcnt) < vs_min) vs_min = int'(s_vcnt);
        if (int'(s_vcnt) > vs_max) vs_max = int'(s_vcnt);
      end
      if (s_vsync != prev_vs && s_hcnt != 5'd0) vs_midline++;
      prev_vs = s_vsync;
      if (!s_irq_n && prev_irq) begin irq_v = int'(s_vcnt); irq_h = int'(s_hcnt); end
      prev_irq = s_irq_n;
      if (s_frame_start && fc_idx < 4) begin fc[fc_idx] = int'(s_frame_cnt); fc_idx++; end
    end
    check("frame model mismatches", 32'(mm), 32'd0);
    check("vblank rise vcnt", 32'(vb_rise), 32'd6);
    check("vsync first line", 32'(vs_min), 32'd7);
    check("vsync last line", 32'(vs_max), 32'd8);
    check("vsync mid-line changes", 32'(vs_midline), 32'd0);
    check("frame_start count", 32'(fc_idx), 32'd4);
    check("frame_cnt at frame 1", 32'(fc[0]), 32'd1);
    check("frame_cnt at frame 2", 32'(fc[1]), 32'd2);
    check("frame_cnt at frame 3", 32'(fc[2]), 32'd3);
    check("frame_cnt wraps to 0", 32'(fc[3]), 32'd0);
    check("irq fall vcnt", 32'(irq_v), 32'd6);
    check("irq fall hcnt", 32'(irq_h), 32'd0);

    // Acknowledge with pix_ce low still clears the IRQ.
    run_to(8, 0, "ack point");
    check("irq pending before ack", 32'(s_irq_n), 32'd0);
    pix_ce = 1'b0; irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    check("irq cleared by ack", 32'(s_irq_n), 32'd1);
    check("hcnt held during ack", 32'(s_hcnt), 32'd0);
    pix_ce = 1'b1;

    // Set and acknowledge on the same edge: set wins.
    run_to(5, 15, "pre-irq point");
    check("irq idle before set", 32'(s_irq_n), 32'd1);
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    check("set wins position", 32'({s_vcnt, s_hcnt}), 32'({4'd6, 5'd0}));
    check("set wins irq_n", 32'(s_irq_n), 32'd0);
    tick();
    check("irq stays low without ack", 32'(s_irq_n), 32'd0);

    // Reset mid-frame with the IRQ pending.
    run_to(8, 13, "mid-frame point");
    check("irq pending before reset", 32'(s_irq_n), 32'd0);
    rst_n = 1'b0; tick();
    check("mid rst hcnt", 32'(s_hcnt), 32'd0);
    check("mid rst vcnt", 32'(s_vcnt), 32'd0);
    check("mid rst irq_n", 32'(s_irq_n), 32'd1);
    check("mid rst strobes", 32'({s_line_start, s_frame_start, s_tile_load}), 32'd0);
    check("mid rst default hcnt", 32'(d_hcnt), 32'd0);
    rst_n = 1'b1; tick();
    check("post rst hcnt", 32'(s_hcnt), 32'd1);
    check("post rst line_start", 32'(s_line_start), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
